// File: rtl/half_adder_str_if.sv
// Lane data bus for half_adder_str: a/b operands in, registered sum/carry,
// valid flag and carry-event tally out.
interface half_adder_str_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             out_valid;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output a, b, in_valid,
    input  sum, carry, out_valid, carry_cnt
  );

  modport slave (
    input  a, b, in_valid,
    output sum, carry, out_valid, carry_cnt
  );
endinterface

// File: rtl/half_adder_str.sv
// Gate-level half-adder lanes with a one-cycle registered output stage
// and a saturating count of accepted inputs that produced any carry.
module half_adder_str_lane (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);
  xor u_xor (o_sum, i_a, i_b);
  and u_and (o_carry, i_a, i_b);
endmodule

module half_adder_str #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  half_adder_str_if.slave ifc
);
  localparam int STAGES = 1;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic [CNT_W-1:0] r_carry_cnt;
  logic [STAGES:1]  r_vld_pipe;
  logic             w_cnt_inc;

  half_adder_str_lane u_lane [WIDTH-1:0] (
    .i_a     (ifc.a),
    .i_b     (ifc.b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Counter stops at all-ones instead of wrapping.
  assign w_cnt_inc = ifc.in_valid && (|w_carry) && (r_carry_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_vld_pipe  <= '0;
      r_carry_cnt <= '0;
    end else begin
      r_vld_pipe[1] <= ifc.in_valid;
      if (ifc.in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
      if (w_cnt_inc) r_carry_cnt <= r_carry_cnt + 1'b1;
    end
  end

  assign ifc.sum       = r_sum;
  assign ifc.carry     = r_carry;
  assign ifc.out_valid = r_vld_pipe[STAGES];
  assign ifc.carry_cnt = r_carry_cnt;
endmodule

// File: tb/tb_half_adder_str.sv
// Directed bench for half_adder_str: WIDTH=1, WIDTH=4 and CNT_W=2 instances.
module tb_half_adder_str;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  half_adder_str_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  half_adder_str_if #(.WIDTH(4), .CNT_W(16)) if4 ();
  half_adder_str_if #(.WIDTH(1), .CNT_W(2))  ifs ();

  half_adder_str #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .ifc(if1));
  half_adder_str #(.WIDTH(4), .CNT_W(16)) dut4 (.clk(clk), .rst(rst), .ifc(if4));
  half_adder_str #(.WIDTH(1), .CNT_W(2))  duts (.clk(clk), .rst(rst), .ifc(ifs));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
    if4.a = 4'hF; if4.b = 4'hF; if4.in_valid = 1'b1;
    ifs.a = 1'b1; ifs.b = 1'b1; ifs.in_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (if1.sum !== 1'b0) begin failures++; $display("FAIL reset_sum got=%b exp=0", if1.sum); end
    checks++;
    if (if1.carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", if1.carry); end
    checks++;
    if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if1.out_valid); end
    checks++;
    if (if1.carry_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", if1.carry_cnt); end
    checks++;
    if (if4.sum !== 4'h0 || if4.carry !== 4'h0 || if4.carry_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_w4 got sum=%b carry=%b cnt=%0d exp 0000/0000/0", if4.sum, if4.carry, if4.carry_cnt);
    end
    checks++;
    if (ifs.carry_cnt !== 2'd0 || ifs.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_sat got cnt=%0d vld=%b exp 0/0", ifs.carry_cnt, ifs.out_valid);
    end
    if4.in_valid = 1'b0;
    ifs.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_exhaustive();
    logic [1:0] vin  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] vexp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      if1.a = vin[i][1]; if1.b = vin[i][0]; if1.in_valid = 1'b1;
      tick();
      checks++;
      if ({if1.sum, if1.carry} !== vexp[i] || if1.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL exh_%0d got sum,carry=%b%b vld=%b exp %b vld=1",
                 i, if1.sum, if1.carry, if1.out_valid, vexp[i]);
      end
    end
    checks++;
    if (if1.carry_cnt !== 16'd1) begin failures++; $display("FAIL exh_cnt got=%0d exp=1", if1.carry_cnt); end
  endtask

  task automatic test_hold();
    if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
    tick();
    checks++;
    if (if1.carry_cnt !== 16'd2) begin failures++; $display("FAIL hold_pre_cnt got=%0d exp=2", if1.carry_cnt); end
    if1.a = 1'b0; if1.b = 1'b0; if1.in_valid = 1'b0;
    tick();
    checks++;
    if (if1.sum !== 1'b0 || if1.carry !== 1'b1) begin
      failures++;
      $display("FAIL hold_data got sum=%b carry=%b exp sum=0 carry=1", if1.sum, if1.carry);
    end
    checks++;
    if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL hold_vld got=%b exp=0", if1.out_valid); end
    checks++;
    if (if1.carry_cnt !== 16'd2) begin failures++; $display("FAIL hold_cnt got=%0d exp=2", if1.carry_cnt); end
  endtask

  task automatic test_midreset();
    if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
    tick();
    checks++;
    if (if1.carry_cnt !== 16'd3) begin failures++; $display("FAIL mrst_pre_cnt got=%0d exp=3", if1.carry_cnt); end
    rst = 1'b1;
    tick();
    checks++;
    if (if1.sum !== 1'b0 || if1.carry !== 1'b0 || if1.out_valid !== 1'b0 || if1.carry_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mrst_clear got sum=%b carry=%b vld=%b cnt=%0d exp 0/0/0/0",
               if1.sum, if1.carry, if1.out_valid, if1.carry_cnt);
    end
    rst = 1'b0;
    if1.a = 1'b0; if1.b = 1'b1;
    tick();
    checks++;
    if (if1.sum !== 1'b1 || if1.carry !== 1'b0 || if1.out_valid !== 1'b1 || if1.carry_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mrst_resume got sum=%b carry=%b vld=%b cnt=%0d exp 1/0/1/0",
               if1.sum, if1.carry, if1.out_valid, if1.carry_cnt);
    end
    if1.in_valid = 1'b0;
  endtask

  task automatic test_width4();
    logic [3:0] va [3] = '{4'b1100, 4'b0101, 4'b0000};
    logic [3:0] vb [3] = '{4'b1010, 4'b0011, 4'b1111};
    logic [3:0] es [3] = '{4'b0110, 4'b0110, 4'b1111};
    logic [3:0] ec [3] = '{4'b1000, 4'b0001, 4'b0000};
    int         en [3] = '{1, 2, 2};
    for (int i = 0; i < 3; i++) begin
      if4.a = va[i]; if4.b = vb[i]; if4.in_valid = 1'b1;
      tick();
      checks++;
      if (if4.sum !== es[i] || if4.carry !== ec[i] || if4.carry_cnt !== 16'(en[i])) begin
        failures++;
        $display("FAIL w4_%0d got sum=%b carry=%b cnt=%0d exp sum=%b carry=%b cnt=%0d",
                 i, if4.sum, if4.carry, if4.carry_cnt, es[i], ec[i], en[i]);
      end
    end
    if4.in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    ifs.a = 1'b1; ifs.b = 1'b1; ifs.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifs.carry_cnt !== 2'(exp_cnt[i])) begin
        failures++;
        $display("FAIL sat_%0d got=%0d exp=%0d", i, ifs.carry_cnt, exp_cnt[i]);
      end
    end
    ifs.in_valid = 1'b0;
    tick();
    checks++;
    if (ifs.carry_cnt !== 2'd3 || ifs.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_hold got cnt=%0d vld=%b exp 3/0", ifs.carry_cnt, ifs.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_hold();
    test_midreset();
    test_width4();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
